// File: rtl/matrix_scan_bcm.sv
// HUB75-style LED matrix scanner with binary code modulation.
// Shifts the next (row, plane) while the current one is displayed.
module matrix_scan_bcm #(
  parameter int PIXEL_WIDTH             = 64,
  parameter int PIXEL_HALFHEIGHT        = 16,
  parameter int BRIGHTNESS_LEVELS       = 6,
  parameter int BRIGHTNESS_BASE_TIMEOUT = 32,
  parameter int BLANK_CYCLES            = 2,
  localparam int ROW_BITS =
    (PIXEL_HALFHEIGHT > 1) ? $clog2(PIXEL_HALFHEIGHT) : 1,
  localparam int COL_BITS =
    (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic [7:0]                   global_dim,
  output logic [COL_BITS-1:0]          column_address,
  output logic [ROW_BITS-1:0]          row_address,
  output logic [ROW_BITS-1:0]          row_address_active,
  output logic                         clk_pixel_load,
  output logic                         clk_pixel,
  output logic                         row_latch,
  output logic                         output_enable,
  output logic [BRIGHTNESS_LEVELS-1:0] brightness_mask,
  output logic                         frame_start
);

  localparam int PL_BITS =
    (BRIGHTNESS_LEVELS > 1) ? $clog2(BRIGHTNESS_LEVELS) : 1;
  localparam int MAX_T =
    BRIGHTNESS_BASE_TIMEOUT << (BRIGHTNESS_LEVELS - 1);
  localparam int TW = $clog2(MAX_T + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int PW = TW + 9;

  localparam logic [1:0] S_SHIFT = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [COL_BITS-1:0] COL_LAST =
    COL_BITS'(PIXEL_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST =
    ROW_BITS'(PIXEL_HALFHEIGHT - 1);
  localparam logic [PL_BITS-1:0] PL_LAST =
    PL_BITS'(BRIGHTNESS_LEVELS - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'(BLANK_CYCLES - 1);

  logic                run_q, run_d;
  logic [1:0]          state_q, state_d;
  logic                phase_q, phase_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [ROW_BITS-1:0] act_q, act_d;
  logic [PL_BITS-1:0]  plane_q, plane_d;
  logic [BW-1:0]       blk_q, blk_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       len_q, len_d;
  logic [TW-1:0]       on_q, on_d;
  logic [7:0]          dim_q, dim_d;

  logic                fs;
  logic                done;
  logic [TW-1:0]       t_lat;
  logic [PW-1:0]       prod;

  // Scan sequencing, display timer and BCM on-time computation
  always_comb begin
    run_d   = run_q;
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    act_d   = act_q;
    plane_d = plane_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    on_d    = on_q;
    dim_d   = dim_q;
    fs = run_q && (state_q == S_SHIFT) && !phase_q &&
         (col_q == '0) && (row_q == '0) && (plane_q == '0);
    done  = (cnt_q >= len_q);
    t_lat = TW'(BRIGHTNESS_BASE_TIMEOUT) << plane_q;
    prod  = PW'(t_lat) * PW'({1'b0, dim_q} + 9'd1);
    if (!done) cnt_d = cnt_q + TW'(1);
    if (fs) dim_d = global_dim;
    if (!run_q) begin
      run_d = 1'b1;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q == COL_LAST) begin
              col_d   = '0;
              blk_d   = '0;
              state_d = done ? S_BLANK : S_WAIT;
            end else begin
              col_d = col_q + COL_BITS'(1);
            end
          end
        end
        S_WAIT: begin
          if (done) begin
            blk_d   = '0;
            state_d = S_BLANK;
          end
        end
        S_BLANK: begin
          if (blk_q == BLK_LAST) state_d = S_LATCH;
          else blk_d = blk_q + BW'(1);
        end
        default: begin
          act_d   = row_q;
          cnt_d   = '0;
          len_d   = t_lat;
          on_d    = TW'(prod >> 8);
          state_d = S_SHIFT;
          if (plane_q == PL_LAST) begin
            plane_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_BITS'(1);
          end else begin
            plane_d = plane_q + PL_BITS'(1);
          end
        end
      endcase
    end
  end

  // State registers; timer starts expired so the first load latches at once
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      state_q <= S_SHIFT;
      phase_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      act_q   <= '0;
      plane_q <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      on_q    <= '0;
      dim_q   <= 8'hFF;
    end else begin
      run_q   <= run_d;
      state_q <= state_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      act_q   <= act_d;
      plane_q <= plane_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      on_q    <= on_d;
      dim_q   <= dim_d;
    end
  end

  assign column_address     = col_q;
  assign row_address        = row_q;
  assign row_address_active = act_q;
  assign clk_pixel_load     = run_q && (state_q == S_SHIFT) && !phase_q;
  assign clk_pixel          = (state_q == S_SHIFT) && phase_q;
  assign row_latch          = (state_q == S_LATCH);
  assign output_enable      = run_q && (cnt_q < on_q) &&
                              ((state_q == S_SHIFT) || (state_q == S_WAIT));
  assign brightness_mask    = BRIGHTNESS_LEVELS'(1) << plane_q;
  assign frame_start        = fs;

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Directed bench for matrix_scan_bcm.
// Small 4x4 panel, 3 planes, base 4, 2 blank cycles.
module tb_matrix_scan_bcm;

  logic       clk_in;
  logic       reset;
  logic [7:0] global_dim;
  logic [1:0] column_address;
  logic [1:0] row_address;
  logic [1:0] row_address_active;
  logic       clk_pixel_load;
  logic       clk_pixel;
  logic       row_latch;
  logic       output_enable;
  logic [2:0] brightness_mask;
  logic       frame_start;

  int tests;
  int fails;

  matrix_scan_bcm #(
    .PIXEL_WIDTH(4),
    .PIXEL_HALFHEIGHT(4),
    .BRIGHTNESS_LEVELS(3),
    .BRIGHTNESS_BASE_TIMEOUT(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .global_dim(global_dim),
    .column_address(column_address),
    .row_address(row_address),
    .row_address_active(row_address_active),
    .clk_pixel_load(clk_pixel_load),
    .clk_pixel(clk_pixel),
    .row_latch(row_latch),
    .output_enable(output_enable),
    .brightness_mask(brightness_mask),
    .frame_start(frame_start)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_latch(input logic [2:0] m, input int row,
                            output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (row_latch && brightness_mask == m &&
          (row < 0 || int'(row_address) == row)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_oe(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (row_latch) begin
        ok = 1'b1;
        break;
      end
      if (output_enable) n++;
    end
  endtask

  task automatic test_startup(input string tag);
    logic [14:0] got, exp;
    logic [6:0]  g7, e7;
    int c;
    tests++;
    got = {column_address, row_address, row_address_active,
           clk_pixel_load, clk_pixel, row_latch, output_enable,
           brightness_mask, frame_start};
    exp = {2'd0, 2'd0, 2'd0, 4'b0000, 3'b001, 1'b0};
    if (got !== exp) begin
      fails++;
      $display("FAIL %s_in_reset got=%b exp=%b", tag, got, exp);
    end
    @(negedge clk_in);
    reset = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      c = (e < 8) ? e / 2 : 0;
      e7 = {(e == 0), 2'(c),
            ((e < 8 && e % 2 == 0) || e == 11),
            (e < 8 && e % 2 == 1),
            (e == 10), (e == 11)};
      g7 = {frame_start, column_address, clk_pixel_load,
            clk_pixel, row_latch, output_enable};
      tests++;
      if (g7 !== e7) begin
        fails++;
        $display("FAIL %s_edge%0d got=%b exp=%b", tag, e, g7, e7);
      end
    end
    tests++;
    if ({row_address, row_address_active, brightness_mask}
        !== {2'd0, 2'd0, 3'b010}) begin
      fails++;
      $display("FAIL %s_after_latch row=%0d act=%0d mask=%b exp 0 0 010",
               tag, row_address, row_address_active, brightness_mask);
    end
  endtask

  task automatic test_oe_width();
    bit ok, ok2;
    int n;
    wait_latch(3'b100, -1, ok);
    count_oe(n, ok2);
    tests++;
    if (!ok || !ok2 || n !== 16) begin
      fails++;
      $display("FAIL oe_p2_dim255 got=%0d exp=16 ok=%0d%0d", n, ok, ok2);
    end
    global_dim = 8'd127;
    wait_fs(ok);
    wait_latch(3'b100, -1, ok2);
    count_oe(n, ok2);
    tests++;
    if (!ok || !ok2 || n !== 8) begin
      fails++;
      $display("FAIL oe_p2_dim127 got=%0d exp=8 ok=%0d%0d", n, ok, ok2);
    end
    global_dim = 8'd0;
    wait_fs(ok);
    wait_latch(3'b001, 0, ok2);
    count_oe(n, ok2);
    tests++;
    if (!ok || !ok2 || n !== 0) begin
      fails++;
      $display("FAIL oe_p0_dim0 got=%0d exp=0 ok=%0d%0d", n, ok, ok2);
    end
    count_oe(n, ok2);
    tests++;
    if (!ok2 || n !== 0) begin
      fails++;
      $display("FAIL oe_p1_dim0 got=%0d exp=0 ok=%0d", n, ok2);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    wait_latch(3'b100, 3, ok);
    tick();
    tests++;
    if (!ok || {row_address, brightness_mask, frame_start,
                row_address_active} !== {2'd0, 3'b001, 1'b1, 2'd3}) begin
      fails++;
      $display("FAIL wrap row=%0d mask=%b fs=%b act=%0d exp 0 001 1 3",
               row_address, brightness_mask, frame_start,
               row_address_active);
    end
    tick();
    tests++;
    if (frame_start !== 1'b0) begin
      fails++;
      $display("FAIL wrap_fs_pulse got=%b exp=0", frame_start);
    end
  endtask

  task automatic test_midframe();
    bit ok, ok2;
    int n;
    global_dim = 8'd255;
    wait_fs(ok);
    wait_latch(3'b001, 1, ok2);
    global_dim = 8'd63;
    wait_latch(3'b100, 1, ok2);
    count_oe(n, ok2);
    tests++;
    if (!ok || !ok2 || n !== 16) begin
      fails++;
      $display("FAIL mid_same_frame got=%0d exp=16 ok=%0d%0d", n, ok, ok2);
    end
    wait_fs(ok);
    wait_latch(3'b100, 0, ok2);
    count_oe(n, ok2);
    tests++;
    if (!ok || !ok2 || n !== 4) begin
      fails++;
      $display("FAIL mid_next_frame got=%0d exp=4 ok=%0d%0d", n, ok, ok2);
    end
  endtask

  task automatic test_blank_guard();
    logic p1, p2;
    int n;
    global_dim = 8'd255;
    n = 0;
    tick();
    p2 = output_enable;
    tick();
    p1 = output_enable;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (row_latch) begin
        n++;
        tests++;
        if ({p2, p1, output_enable} !== 3'b000) begin
          fails++;
          $display("FAIL blank_guard latch%0d oe_hist=%b exp=000",
                   n, {p2, p1, output_enable});
        end
      end
      p2 = p1;
      p1 = output_enable;
    end
    tests++;
    if (n < 10) begin
      fails++;
      $display("FAIL blank_latch_count got=%0d exp>=10", n);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (output_enable) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (!ok || output_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_oe got=%b exp=0 found_oe=%0d",
               output_enable, ok);
    end
    test_startup("restart");
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    global_dim = 8'd255;
    reset      = 1'b0;
    #23;
    test_startup("init");
    test_oe_width();
    test_wrap();
    test_midframe();
    test_blank_guard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_scan_bcm.md
MATRIX_SCAN_BCM -- requirements
Module: matrix_scan_bcm

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 64, columns per row shifted per load.
REQ-002 SHALL have parameter PIXEL_HALFHEIGHT, default 16, rows per half-panel; ROW_BITS = max(1, clog2(PIXEL_HALFHEIGHT)).
REQ-003 SHALL have parameter BRIGHTNESS_LEVELS, default 6, number of BCM bit-planes (1..8).
REQ-004 SHALL have parameter BRIGHTNESS_BASE_TIMEOUT, default 32, display cycles of plane 0; plane b gets BASE<<b.
REQ-005 SHALL have parameter BLANK_CYCLES, default 2, anti-ghost blank cycles before each latch (>=1).
REQ-006 SHALL have port clk_in, input, 1, sole clock; all state changes on rising edge.
REQ-007 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port global_dim, input, 8, global brightness 0..255.
REQ-009 SHALL have port column_address, output, clog2(PIXEL_WIDTH), column being shifted.
REQ-010 SHALL have port row_address, output, ROW_BITS, row being shifted.
REQ-011 SHALL have port row_address_active, output, ROW_BITS, row currently latched/displayed.
REQ-012 SHALL have port clk_pixel_load, output, 1, high in the data-setup cycle of each pixel.
REQ-013 SHALL have port clk_pixel, output, 1, high in the shift-edge cycle of each pixel.
REQ-014 SHALL have port row_latch, output, 1, one-cycle latch strobe.
REQ-015 SHALL have port output_enable, output, 1, high = LEDs lit.
REQ-016 SHALL have port brightness_mask, output, BRIGHTNESS_LEVELS, one-hot plane being shifted.
REQ-017 SHALL have port frame_start, output, 1, one-cycle pulse when row 0 plane 0 shifting begins.

Function
REQ-018 SHALL scan order: rows 0..PIXEL_HALFHEIGHT-1 outer, planes LSB..MSB inner; after last row/MSB wrap to row 0 plane 0.
REQ-019 SHALL shift each (row, plane) as PIXEL_WIDTH pixels, 2 cycles each: cycle A clk_pixel_load=1, cycle B clk_pixel=1; column_address 0..PIXEL_WIDTH-1, held across A and B.
REQ-020 SHALL run shifting of the next (row, plane) concurrently with display of the current one (pipelined).
REQ-021 SHALL use states SHIFT, WAIT, BLANK, LATCH: SHIFT -> WAIT when last pixel done; WAIT -> BLANK when display timer expired; BLANK -> LATCH after BLANK_CYCLES; LATCH -> SHIFT next cycle.
REQ-022 SHALL hold output_enable=0 in BLANK and LATCH.
REQ-023 SHALL, in LATCH, assert row_latch one cycle, load row_address_active from row_address, restart display timer at T = BASE<<b for the latched plane b.
REQ-024 SHALL drive output_enable=1 for the first ON = (T*(global_dim+1))>>8 timer cycles, then 0 for the remainder of T; ON=0 keeps OE low.
REQ-025 SHALL extend display (OE low) when shift is slower than T; latching waits for both conditions.
REQ-026 SHALL sample global_dim only in the frame_start cycle; mid-frame changes take effect next frame.
REQ-027 SHALL treat the display timer as expired after reset, so the first load latches without waiting.
REQ-028 SHALL compute timer widths wide enough for BASE<<(BRIGHTNESS_LEVELS-1) without overflow.

Reset
REQ-029 SHALL, while reset=0, drive column_address, row_address, row_address_active, clk_pixel_load, clk_pixel, row_latch, output_enable=0, brightness_mask=1, frame_start=0, state SHIFT, sampled dim=255.
REQ-030 SHALL, on assertion mid-operation, clear outputs immediately (asynchronous); after release, first edge starts row 0 plane 0 with frame_start=1.

Verification (PIXEL_WIDTH=4, PIXEL_HALFHEIGHT=4, LEVELS=3, BASE=4, BLANK_CYCLES=2)
REQ-031 SHALL check reset release -> frame_start on edge 0, column_address 0,0,1,1,2,2,3,3 over edges 0-7, clk_pixel on odd edges, row_latch on edge 10, first OE on edge 11.
REQ-032 SHALL check global_dim=255 -> plane2 OE high exactly 16 cycles; global_dim=127 -> exactly 8; global_dim=0 -> plane0 OE high exactly 0 cycles (ON=(4*1)>>8).
REQ-033 SHALL check wrap: after row 3 brightness_mask=100 shift -> row_address=0, brightness_mask=001, frame_start one cycle.
REQ-034 SHALL check global_dim changed 255->63 mid-frame -> OE widths unchanged until next frame_start, then plane2 OE=4 cycles.
REQ-035 SHALL check reset asserted during OE high -> output_enable=0 before next clk_in edge; restart matches REQ-031.
REQ-036 SHALL check output_enable=0 in the 2 cycles before every row_latch and in the latch cycle.
